// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment codes, widths and reader FSM states
package seg7_pkg;

    localparam int DIGIT_W = 7;
    localparam int SEG_W   = 2 * DIGIT_W;
    localparam int VALUE_W = 4;

    // Segment order a..g, MSB first, lit = 1.
    localparam logic [DIGIT_W-1:0] CODE_0 = 7'b1111110;
    localparam logic [DIGIT_W-1:0] CODE_1 = 7'b0110000;
    localparam logic [DIGIT_W-1:0] CODE_2 = 7'b1101101;
    localparam logic [DIGIT_W-1:0] CODE_3 = 7'b1111001;
    localparam logic [DIGIT_W-1:0] CODE_4 = 7'b0110011;
    localparam logic [DIGIT_W-1:0] CODE_5 = 7'b1011011;
    localparam logic [DIGIT_W-1:0] CODE_6 = 7'b1011111;
    localparam logic [DIGIT_W-1:0] CODE_7 = 7'b1110000;
    localparam logic [DIGIT_W-1:0] CODE_8 = 7'b1111111;
    localparam logic [DIGIT_W-1:0] CODE_9 = 7'b1110011;
    localparam logic [DIGIT_W-1:0] BLANK  = 7'b0000000;

    typedef enum logic {
        TRACK,
        HOLD
    } state_t;

    function automatic logic [DIGIT_W-1:0] digit_code(input logic [3:0] digit);
        case (digit)
            4'd0:    return CODE_0;
            4'd1:    return CODE_1;
            4'd2:    return CODE_2;
            4'd3:    return CODE_3;
            4'd4:    return CODE_4;
            4'd5:    return CODE_5;
            4'd6:    return CODE_6;
            4'd7:    return CODE_7;
            4'd8:    return CODE_8;
            4'd9:    return CODE_9;
            default: return BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// rtl/seg7_digit_dec.sv - one seven-segment code to binary digit plus legal flag
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [3:0]         digit,
    output logic               legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (code)
            CODE_0:  digit = 4'd0;
            CODE_1:  digit = 4'd1;
            CODE_2:  digit = 4'd2;
            CODE_3:  digit = 4'd3;
            CODE_4:  digit = 4'd4;
            CODE_5:  digit = 4'd5;
            CODE_6:  digit = 4'd6;
            CODE_7:  digit = 4'd7;
            CODE_8:  digit = 4'd8;
            CODE_9:  digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - debounces a two-digit display pattern and emits its value once per stable pattern
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [SEG_W-1:0]     SEG_IN,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [VALUE_W-1:0]   VALUE,
    output logic                 ERR,
    output logic                 OVERRUN
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [SEG_W-1:0]   seg_q;
    logic [7:0]         run;
    logic [7:0]         run_next;
    state_t             state;
    state_t             state_next;
    logic               decode_event;

    logic [3:0]         tens_digit;
    logic [3:0]         units_digit;
    logic               tens_legal;
    logic               units_legal;
    logic [4:0]         sum;
    logic               dec_ok;
    logic [VALUE_W-1:0] dec_value;

    always_comb begin
        run_next = 8'd1;
        if (SEG_IN == seg_q) begin
            run_next = (run == STABLE) ? STABLE : run + 8'd1;
        end
    end

    // Reset clears seg_q, so the first post-reset edge looks like a change unless the display is blank.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_q <= '0;
            run   <= 8'd0;
        end else begin
            seg_q <= SEG_IN;
            run   <= run_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= TRACK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        decode_event = 1'b0;
        case (state)
            TRACK: begin
                if (run_next == STABLE) begin
                    state_next   = HOLD;
                    decode_event = (seg_q != '0);
                end
            end
            HOLD: begin
                if (SEG_IN != seg_q) begin
                    state_next = TRACK;
                end
            end
            default: state_next = TRACK;
        endcase
    end

    seg7_digit_dec u_tens (
        .code  (seg_q[SEG_W-1:DIGIT_W]),
        .digit (tens_digit),
        .legal (tens_legal)
    );

    seg7_digit_dec u_units (
        .code  (seg_q[DIGIT_W-1:0]),
        .digit (units_digit),
        .legal (units_legal)
    );

    // Only 0 or 1 is accepted in the tens place, so the sum never exceeds 19 and fits 5 bits.
    always_comb begin
        sum       = ((tens_digit == 4'd1) ? 5'd10 : 5'd0) + {1'b0, units_digit};
        dec_ok    = tens_legal && units_legal && (tens_digit <= 4'd1) && (sum <= 5'd15);
        dec_value = dec_ok ? sum[VALUE_W-1:0] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            VALUE     <= '0;
            ERR       <= 1'b0;
            OVERRUN   <= 1'b0;
        end else if (decode_event) begin
            if (!OUT_VALID || OUT_READY) begin
                OUT_VALID <= 1'b1;
                VALUE     <= dec_value;
                ERR       <= !dec_ok;
            end else begin
                OVERRUN   <= 1'b1;
            end
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed and randomized checks of seg7_reader against a behavioural model
module tb_seg7_reader;

    localparam int S = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [13:0] SEG_IN = 14'd0;
    logic        OUT_READY = 1'b0;
    logic        OUT_VALID;
    logic [3:0]  VALUE;
    logic        ERR;
    logic        OVERRUN;

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SEG_IN    (SEG_IN),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .VALUE     (VALUE),
        .ERR       (ERR),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    int errors = 0;
    int checks = 0;

    logic [13:0] m_prev   = 14'd0;
    int          m_streak = 0;
    logic        m_valid  = 1'b0;
    logic [3:0]  m_value  = 4'd0;
    logic        m_err    = 1'b0;
    logic        m_ovr    = 1'b0;
    int          pulses   = 0;
    logic        last_valid = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_code(input logic [6:0] c);
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic logic [13:0] two(input int t, input int u);
        return {codes[t], codes[u]};
    endfunction

    task automatic ref_decode(input logic [13:0] p, output logic [3:0] v, output logic e);
        int t;
        int u;
        t = find_code(p[13:7]);
        u = find_code(p[6:0]);
        if (t >= 0 && t <= 1 && u >= 0 && (t * 10 + u) <= 15) begin
            v = 4'(t * 10 + u);
            e = 1'b0;
        end else begin
            v = 4'd0;
            e = 1'b1;
        end
    endtask

    task automatic step(input logic [13:0] pat, input logic rdy, input logic rst);
        logic [3:0] v;
        logic       e;
        SEG_IN    = pat;
        OUT_READY = rdy;
        RST       = rst;
        @(posedge CLK);
        if (rst) begin
            m_prev   = 14'd0;
            m_streak = 0;
            m_valid  = 1'b0;
            m_value  = 4'd0;
            m_err    = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            if (pat == m_prev) m_streak++;
            else m_streak = 1;
            m_prev = pat;
            if (m_streak == S && pat != 14'd0) begin
                ref_decode(pat, v, e);
                if (!m_valid || rdy) begin
                    m_valid = 1'b1;
                    m_value = v;
                    m_err   = e;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 16'(OUT_VALID), 16'(m_valid));
        check("overrun", 16'(OVERRUN), 16'(m_ovr));
        if (m_valid || rst) begin
            check("value", 16'(VALUE), 16'(m_value));
            check("err", 16'(ERR), 16'(m_err));
        end
        if (OUT_VALID && !last_valid) pulses++;
        last_valid = OUT_VALID;
    endtask

    initial begin
        int kind;
        int len;
        logic [13:0] p;

        step(14'd0, 1'b0, 1'b1);
        step(14'd0, 1'b0, 1'b1);
        check("rst_valid", 16'(OUT_VALID), 16'd0);
        check("rst_value", 16'(VALUE), 16'd0);
        check("rst_overrun", 16'(OVERRUN), 16'd0);

        repeat (3) step(two(0, 5), 1'b1, 1'b0);
        check("five_early", 16'(OUT_VALID), 16'd0);
        step(two(0, 5), 1'b1, 1'b0);
        check("five_valid", 16'(OUT_VALID), 16'd1);
        check("five_value", 16'(VALUE), 16'd5);
        check("five_err", 16'(ERR), 16'd0);
        step(two(0, 5), 1'b1, 1'b0);
        check("five_drop", 16'(OUT_VALID), 16'd0);

        repeat (3) step(two(1, 5), 1'b1, 1'b0);
        step(14'd0, 1'b1, 1'b0);
        check("fifteen_short", 16'(OUT_VALID), 16'd0);
        repeat (4) step(two(1, 5), 1'b1, 1'b0);
        check("fifteen_valid", 16'(OUT_VALID), 16'd1);
        check("fifteen_value", 16'(VALUE), 16'd15);

        repeat (4) step(two(1, 7), 1'b1, 1'b0);
        check("seventeen_err", 16'(ERR), 16'd1);
        check("seventeen_value", 16'(VALUE), 16'd0);
        repeat (4) step({codes[0], 7'b0000001}, 1'b1, 1'b0);
        check("unknown_err", 16'(ERR), 16'd1);
        check("unknown_valid", 16'(OUT_VALID), 16'd1);

        step(14'd0, 1'b1, 1'b0);
        repeat (4) step(two(0, 3), 1'b0, 1'b0);
        check("three_value", 16'(VALUE), 16'd3);
        repeat (4) step(two(0, 7), 1'b0, 1'b0);
        check("ovr_value", 16'(VALUE), 16'd3);
        check("ovr_set", 16'(OVERRUN), 16'd1);
        step(two(0, 7), 1'b1, 1'b0);
        check("ovr_drain", 16'(OUT_VALID), 16'd0);
        check("ovr_sticky", 16'(OVERRUN), 16'd1);

        pulses = 0;
        repeat (20) step(two(0, 9), 1'b1, 1'b0);
        check("nine_pulses", 16'(pulses), 16'd1);
        pulses = 0;
        repeat (10) step(14'd0, 1'b1, 1'b0);
        check("blank_pulses", 16'(pulses), 16'd0);

        step(two(0, 8), 1'b1, 1'b0);
        step(two(0, 8), 1'b1, 1'b1);
        check("midrst_overrun", 16'(OVERRUN), 16'd0);
        check("midrst_value", 16'(VALUE), 16'd0);
        pulses = 0;
        repeat (2) step(two(0, 8), 1'b1, 1'b0);
        check("midrst_pulses", 16'(pulses), 16'd0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       p = two(int'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
                1:       p = two(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
                2:       p = 14'($urandom);
                default: p = 14'd0;
            endcase
            len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) begin
                step(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive sampling edges a pattern must hold before it is decoded (legal range 2..255).
REQ-002 CLK  input  1  sole clock, rising-edge active.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 SEG_IN  input  14  two-digit display pattern: [13:7] tens digit, [6:0] units digit, each ordered a..g MSB-first, segment lit = 1.
REQ-005 OUT_READY  input  1  consumer accepts the held result.
REQ-006 OUT_VALID  output  1  result held on VALUE/ERR is pending.
REQ-007 VALUE  output  4  decoded binary value 0..15.
REQ-008 ERR  output  1  pending result is an illegal pattern (VALUE forced to 0).
REQ-009 OVERRUN  output  1  sticky: a result was dropped while one was pending.

Function
REQ-010 Digit codes SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
REQ-011 SEG_IN SHALL be registered into SEG_Q every edge; run counter RUN increments (saturating at STABLE_CYCLES) when SEG_IN==SEG_Q, else loads 1.
REQ-012 FSM SHALL have states TRACK (pattern not yet qualified) and HOLD (current pattern already decoded).
REQ-013 TRACK->HOLD on the edge at which RUN reaches STABLE_CYCLES; a decode event occurs on that edge; latency = STABLE_CYCLES edges from first sample of the pattern.
REQ-014 HOLD->TRACK on any edge with SEG_IN!=SEG_Q; no further decode events while in HOLD.
REQ-015 Decode: tens SHALL be code 0 or code 1, units SHALL be codes 0..9; VALUE = tens*10 + units computed at 5 bits, legal only if <=15.
REQ-016 Any non-matching digit code, or sum >15 (e.g. 16..19), SHALL produce ERR=1, VALUE=0.
REQ-017 All-zero SEG_IN (display blank) SHALL qualify into HOLD but produce no decode event.
REQ-018 Decode event with OUT_VALID=0, or with OUT_VALID=1 and OUT_READY=1 on the same edge: load VALUE/ERR, OUT_VALID=1 next cycle.
REQ-019 Decode event with OUT_VALID=1 and OUT_READY=0: held result unchanged, OVERRUN set to 1.
REQ-020 OUT_VALID=1 and OUT_READY=1 with no decode event: OUT_VALID=0 next cycle; VALUE/ERR SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 OVERRUN SHALL clear only on RST.

Reset
REQ-022 RST=1 at an edge SHALL set OUT_VALID=0, VALUE=0, ERR=0, OVERRUN=0, SEG_Q=0, RUN=0, FSM=TRACK, overriding all other events, including mid-qualification or a pending result.
REQ-023 First edge after RST deasserts SHALL be treated as a pattern change (RUN loads 1 unless SEG_IN==0).

Structure
REQ-024 Package seg7_pkg SHALL hold the ten digit codes, BLANK (7'b0), state enum {TRACK,HOLD}, and digit width constants; the existing encoder SHALL be able to share the codes.
REQ-025 One sub-module seg7_digit_dec (7-bit code -> 4-bit digit + legal flag, combinational) SHALL be instantiated twice (tens, units).

Verification
REQ-026 SEG_IN=1111110_1011011 held 4 edges, OUT_READY=1 -> OUT_VALID=1 after edge 4, VALUE=5, ERR=0, then OUT_VALID=0.
REQ-027 SEG_IN=0110000_1011011 held 3 edges then changed -> no OUT_VALID; held 4 edges -> VALUE=15.
REQ-028 SEG_IN=0110000_1110000 (17) held 4 edges -> OUT_VALID=1, ERR=1, VALUE=0; unknown code 0000001 in units -> ERR=1.
REQ-029 OUT_READY=0, decode 3 then 7 -> VALUE stays 3, OVERRUN=1; OUT_READY=1 -> OUT_VALID=0, OVERRUN stays 1.
REQ-030 Pattern 9 held 20 edges -> exactly one OUT_VALID pulse; all-zero held 10 edges -> none.
REQ-031 RST asserted at edge 2 of a 4-edge qualification -> no OUT_VALID, all outputs 0, OVERRUN cleared.
